// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 controller
package ps2_pkg;

  // Transmit handshake states; encoding is fixed so it reads the same in waveforms
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_SEND     = 2'd2,
    ST_BUSY     = 2'd3
  } tx_state_t;

  // Receive FIFO entry is {error, data}
  localparam int ENTRY_W = 9;

endpackage

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - receive FIFO of {error, data} entries with pop-through-full support
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_push_entry,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head,
  output logic               o_full,
  output logic               o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [ENTRY_W-1:0]  r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_pop;
  logic                  w_push;

  // A pop on empty is ignored; a push on full only succeeds when a pop frees the slot
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_full  = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Storage write; contents need no reset since rd_valid gates their use
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_ctrl.sv
// rtl/ps2_ctrl.sv - PS/2 controller: receive buffering, transmit handshake, sticky status
module ps2_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rcv_data,
  input  logic       rcv_error,
  input  logic       rcv_strobe,
  input  logic       xmt_ready,
  output logic [7:0] xmt_data,
  output logic       xmt_strobe,
  output logic [7:0] rd_data,
  output logic       rd_error,
  output logic       rd_valid,
  input  logic       rd_ack,
  input  logic [7:0] wr_data,
  input  logic       wr_strobe,
  output logic       wr_busy,
  output logic       overflow,
  output logic       collision,
  input  logic       flag_clr,
  output logic       irq
);

  tx_state_t          r_state;
  tx_state_t          w_state_next;
  logic [7:0]         r_xmt_data;
  logic               r_overflow;
  logic               r_collision;
  logic               w_xmt_strobe;
  logic               w_wr_busy;
  logic [ENTRY_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_ovf_set;
  logic               w_col_set;
  logic               w_tx_active;

  ps2_rx_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_rx_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (rcv_strobe),
    .i_push_entry ({rcv_error, rcv_data}),
    .i_pop        (rd_ack),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  assign rd_data  = w_head[7:0];
  assign rd_error = w_head[8];
  assign rd_valid = ~w_empty;

  // A byte is lost only when full and nothing is popped alongside it
  assign w_tx_active = (r_state == ST_SEND) || (r_state == ST_BUSY);
  assign w_ovf_set   = rcv_strobe & w_full & ~rd_ack;
  assign w_col_set   = rcv_strobe & w_tx_active;

  // Transmit state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Transmit next-state and outputs; xmt_ready only steers state, never the strobe directly
  always_comb begin
    w_state_next = r_state;
    w_xmt_strobe = 1'b0;
    w_wr_busy    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_wr_busy = 1'b0;
        if (wr_strobe) w_state_next = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (xmt_ready) w_state_next = ST_SEND;
      end
      ST_SEND: begin
        w_xmt_strobe = 1'b1;
        w_state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (xmt_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Command byte is captured only when the transmit path accepts it
  always_ff @(posedge clk) begin
    if (rst)                                 r_xmt_data <= 8'h00;
    else if (r_state == ST_IDLE && wr_strobe) r_xmt_data <= wr_data;
  end

  // Sticky status flags; a new event wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow & ~flag_clr);
      r_collision <= w_col_set | (r_collision & ~flag_clr);
    end
  end

  assign xmt_data   = r_xmt_data;
  assign xmt_strobe = w_xmt_strobe;
  assign wr_busy    = w_wr_busy;
  assign overflow   = r_overflow;
  assign collision  = r_collision;
  assign irq        = rd_valid | r_overflow | r_collision;

endmodule

// File: doc/ps2_ctrl.md
# ps2_ctrl

Controller stage sitting between the PS/2 host line interface and the CPU-side I/O logic. Consumes received bytes (data + error flag) from the host's receiver strobe, buffers them in a receive FIFO, and presents them to a pop-style read port. Accepts single command bytes from the CPU side and feeds them to the host's transmitter handshake. Maintains sticky overflow and collision status flags.

## Interface
Parameters:
- DEPTH_LOG2, 4, log2 of receive FIFO depth (depth = 16 by default)

Ports:
- clk  in  1  system clock; the block has one clock
- rst  in  1  synchronous, active-high reset
- rcv_data  in  8  received byte from host
- rcv_error  in  1  framing/parity error for that byte
- rcv_strobe  in  1  one-cycle pulse: rcv_data/rcv_error valid
- xmt_ready  in  1  host idle with quiet clock line; can accept a byte
- xmt_data  out  8  byte to transmit
- xmt_strobe  out  1  one-cycle transmit request
- rd_data  out  8  head-of-FIFO byte
- rd_error  out  1  error flag stored with head byte
- rd_valid  out  1  FIFO not empty
- rd_ack  in  1  pop head entry
- wr_data  in  8  command byte from CPU side
- wr_strobe  in  1  one-cycle write request
- wr_busy  out  1  transmit path occupied; wr_strobe ignored while high
- overflow  out  1  sticky: byte dropped on full FIFO
- collision  out  1  sticky: byte received while transmit in flight
- flag_clr  in  1  clears overflow and collision
- irq  out  1  rd_valid | overflow | collision

## Operation
- Receive FIFO: 9-bit entries {error, data}, 2^DEPTH_LOG2 deep, read/write pointers DEPTH_LOG2 bits wrapping modulo depth, count DEPTH_LOG2+1 bits.
- Push on rcv_strobe if not full. Pop on rd_ack if not empty; rd_ack on empty is ignored.
- Full and rcv_strobe with no pop: byte dropped, overflow set, FIFO unchanged.
- Full and rcv_strobe with rd_ack same cycle: pop and push both performed, no overflow, count stays at depth.
- Empty and rcv_strobe with rd_ack same cycle: rd_ack ignored, push performed.
- rd_data/rd_error show head entry combinationally from storage; undefined-but-stable content when rd_valid=0 is permitted, bench must not check it.
- Transmit FSM states:
  - IDLE: wr_busy=0. On wr_strobe latch wr_data into xmt_data -> WAIT_RDY.
  - WAIT_RDY: wr_busy=1. When xmt_ready=1 -> SEND.
  - SEND: xmt_strobe=1 for exactly this cycle -> BUSY.
  - BUSY: wr_busy=1. Stays until xmt_ready=1 (host finished frame and line quiet again) -> IDLE.
- rcv_strobe while FSM in SEND or BUSY sets collision (byte still pushed normally). Software decides on retry.
- Flag priority: set beats flag_clr in the same cycle.
- xmt_data holds latched byte until next accepted wr_strobe.

## Timing
- Reset values: xmt_data=0x00, xmt_strobe=0, rd_valid=0, wr_busy=0, overflow=0, collision=0, irq=0; FIFO empty, FSM IDLE.
- Reset mid-transmit returns FSM to IDLE in one cycle; queued bytes discarded.
- rcv_strobe at cycle N -> rd_valid=1 and data visible at N+1.
- rd_ack at N -> next entry (or rd_valid=0) at N+1.
- wr_strobe at N -> wr_busy=1 at N+1; earliest xmt_strobe at N+2 (if xmt_ready=1 at N+1).
- xmt_ready sampled registered-state only; no combinational path from xmt_ready to xmt_strobe.
- overflow/collision set visible the cycle after the causing event; irq combinational from registered signals.

## Structure
- Shared package ps2_pkg: transmit FSM state encoding (IDLE=0, WAIT_RDY=1, SEND=2, BUSY=3), FIFO entry width constant (9).
- One sub-module: ps2_rx_fifo (parameterised by DEPTH_LOG2; push/pop/full/empty/count). FSM and flags in top.

## Test plan
- Push 0x1C, 0xF0, 0x1C via rcv_strobe, pop with rd_ack -> read 0x1C, 0xF0, 0x1C with rd_error=0, then rd_valid=0.
- Push 17 bytes 0x00..0x10 without pops (depth 16) -> overflow=1, popped sequence 0x00..0x0F, 0x10 lost; flag_clr -> overflow=0.
- FIFO full, rcv_strobe 0xAA with rd_ack same cycle -> overflow stays 0, count 16, last entry 0xAA.
- rcv_strobe with rcv_error=1, data 0x55 -> rd_data=0x55, rd_error=1.
- wr_strobe 0xED with xmt_ready=0 for 10 cycles then 1 -> single xmt_strobe pulse with xmt_data=0xED, wr_busy held until xmt_ready returns high; second wr_strobe during busy ignored.
- rcv_strobe during BUSY -> collision=1, byte queued; reset during WAIT_RDY -> xmt_strobe never asserted, all outputs at reset values.
